// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared types, constants and helpers for the seven-segment scan driver.
package seg_disp_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

    // Sized for the widest supported row (8 digits); narrower rows zero-extend.
    function automatic logic [7:0] lz_mask(input logic [31:0] active, input logic lz_en);
        logic [7:0] m;
        m = '0;
        for (int i = 1; i < 8; i++) m[i] = lz_en && ((active >> (DIGIT_W * i)) == 32'd0);
        return m;
    endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed scan driver for a row of common-anode seven-segment digits.
module seg_scan_mux
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
    input  logic                          load,
    input  logic                          lz_blank_en,
    input  logic [NUM_DIGITS-1:0]         dp_mask,
    output logic [DIGIT_W-1:0]            digit_bin,
    output logic                          digit_blank,
    output logic [NUM_DIGITS-1:0]         digit_en_n,
    output logic                          dp_n,
    output logic                          frame_done
);

    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = REFRESH_DIV > 2 ? $clog2(REFRESH_DIV) : 1;
    localparam int VW = DIGIT_W * NUM_DIGITS;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic [IW-1:0]         idx, idx_nx;
    logic [VW-1:0]         sh_val, act_val;
    logic [NUM_DIGITS-1:0] sh_dp, act_dp;
    logic                  sh_lz, act_lz, pending;
    logic                  blank_end, show_end, wrap;
    logic [7:0]            lzm;

    always_comb begin
        blank_end = state == BLANK && cnt == CW'(BLANK_CYCLES - 1);
        show_end  = state == SHOW && cnt == CW'(REFRESH_DIV - BLANK_CYCLES - 1);
        wrap      = show_end && idx == IW'(NUM_DIGITS - 1);
        state_nx  = blank_end ? SHOW : show_end ? BLANK : state;
        cnt_nx    = (blank_end || show_end) ? '0 : cnt + 1'b1;
        idx_nx    = wrap ? '0 : show_end ? idx + 1'b1 : idx;
        lzm       = lz_mask(32'(act_val), act_lz);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BLANK;
            cnt         <= '0;
            idx         <= '0;
            sh_val      <= '0;
            sh_dp       <= '0;
            sh_lz       <= 1'b0;
            act_val     <= '0;
            act_dp      <= '0;
            act_lz      <= 1'b0;
            pending     <= 1'b0;
            digit_bin   <= '0;
            digit_blank <= 1'b1;
            digit_en_n  <= '1;
            dp_n        <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            frame_done <= wrap;
            if (load) begin
                sh_val <= value;
                sh_dp  <= dp_mask;
                sh_lz  <= lz_blank_en;
            end
            // A load landing on the commit cycle goes straight to the active copy.
            if (wrap) begin
                pending <= 1'b0;
                if (load) begin
                    act_val <= value;
                    act_dp  <= dp_mask;
                    act_lz  <= lz_blank_en;
                end else if (pending) begin
                    act_val <= sh_val;
                    act_dp  <= sh_dp;
                    act_lz  <= sh_lz;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
            if (blank_end) begin
                digit_en_n  <= ~(NUM_DIGITS'(1) << idx);
                digit_bin   <= act_val[DIGIT_W*idx +: DIGIT_W];
                digit_blank <= lzm[idx];
                dp_n        <= ~act_dp[idx];
            end else if (show_end) begin
                digit_en_n  <= '1;
                digit_blank <= 1'b1;
                dp_n        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: randomized scoreboard bench with a time-based reference model of the scan.
module tb_seg_scan_mux;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FR = N * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        lz_blank_en = 1'b0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  digit_bin;
    logic        digit_blank;
    logic [3:0]  digit_en_n;
    logic        dp_n;
    logic        frame_done;

    seg_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .lz_blank_en(lz_blank_en),
        .dp_mask(dp_mask), .digit_bin(digit_bin), .digit_blank(digit_blank),
        .digit_en_n(digit_en_n), .dp_n(dp_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] en_n;
        logic [3:0] bin;
        logic       blank;
        logic       dp_n;
        logic       fd;
    } obs_t;

    localparam obs_t RST_OBS = '{en_n: 4'hF, bin: 4'h0, blank: 1'b1, dp_n: 1'b1, fd: 1'b0};

    obs_t        q[$];
    int          checks = 0, fails = 0, k = 0, popped = 0;
    logic [15:0] lat_v, act_v;
    logic [3:0]  lat_dp, act_dp, last_bin;
    logic        lat_lz, act_lz;

    function automatic obs_t dut_obs();
        return '{en_n: digit_en_n, bin: digit_bin, blank: digit_blank, dp_n: dp_n, fd: frame_done};
    endfunction

    task automatic model_reset();
        k = 0; lat_v = '0; act_v = '0; lat_dp = '0; act_dp = '0; lat_lz = 0; act_lz = 0; last_bin = '0;
    endtask

    // Called at a negedge; drives inputs, predicts the state after the next edge, returns at the following negedge.
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] dp, input logic lz);
        obs_t e;
        int o, d;
        load = ld; value = v; dp_mask = dp; lz_blank_en = lz;
        @(posedge clk);
        k++;
        if (ld) begin lat_v = v; lat_dp = dp; lat_lz = lz; end
        e.fd = (k % FR == 0);
        if (e.fd) begin act_v = lat_v; act_dp = lat_dp; act_lz = lat_lz; end
        o = k % RD;
        d = (k / RD) % N;
        if (o >= BC) begin
            e.en_n   = ~(4'b0001 << d);
            last_bin = 4'(act_v >> (4 * d));
            e.blank  = act_lz && d > 0 && ((act_v >> (4 * d)) == 16'd0);
            e.dp_n   = ~act_dp[d];
        end else begin
            e.en_n = 4'hF; e.blank = 1'b1; e.dp_n = 1'b1;
        end
        e.bin = last_bin;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic idle_to(input int m);
        while (k % FR != m) idle(1);
    endtask

    task automatic check_reset(input string tag);
        obs_t a;
        a = dut_obs();
        checks++;
        if (a !== RST_OBS) begin
            fails++;
            $display("FAIL %s: got en=%b bin=%h blank=%b dp=%b fd=%b, want reset values", tag,
                     a.en_n, a.bin, a.blank, a.dp_n, a.fd);
        end
    endtask

    always begin
        obs_t a, e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = dut_obs();
            popped++;
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL scan obs#%0d: got en=%b bin=%h blank=%b dp=%b fd=%b, want en=%b bin=%h blank=%b dp=%b fd=%b",
                         popped, a.en_n, a.bin, a.blank, a.dp_n, a.fd, e.en_n, e.bin, e.blank, e.dp_n, e.fd);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("reset_state");
        rst_n = 1'b1;
        idle(FR + 8);
        idle_to(12);
        step(1'b1, 16'h12AF, 4'b0000, 1'b0);
        idle_to(0);
        idle(FR);
        step(1'b1, 16'h0030, 4'b0000, 1'b1);
        idle_to(0);
        idle(FR);
        step(1'b1, 16'h0000, 4'b0000, 1'b1);
        idle_to(0);
        idle(FR);
        idle_to(5);
        step(1'b1, 16'h1111, 4'b0000, 1'b0);
        idle_to(20);
        step(1'b1, 16'h2222, 4'b0000, 1'b0);
        idle_to(31);
        step(1'b1, 16'h3333, 4'b0000, 1'b0);
        idle(FR);
        step(1'b1, 16'hABCD, 4'b0100, 1'b0);
        idle_to(0);
        idle(FR);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 9) == 0, 16'($urandom), 4'($urandom), 1'($urandom));
        idle_to(0);
        idle_to(18);
        step(1'b1, 16'h7777, 4'b1111, 1'b0);
        step(1'b0, 16'h0000, 4'b0000, 1'b0);
        #1;
        rst_n = 1'b0;
        load = 1'b0;
        #1;
        check_reset("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(2 * FR + 4);
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexed scan driver for a row of common-anode seven-segment digits. Captures a packed hex value, commits it atomically at frame boundaries, and cycles through the digits one at a time. For each digit it presents the 4-bit nibble to the hex-to-segment decoder and drives the matching active-low digit enable. It sits directly upstream of that decoder; a dead-time interval between digits prevents ghosting, and optional leading-zero blanking suppresses unused high digits.

## Interface
- NUM_DIGITS, 4: digits scanned; valid range 1–8.
- REFRESH_DIV, 50000: clk cycles per digit slot (dead time plus display time).
- BLANK_CYCLES, 500: dead-time cycles at the start of each slot; 1 ≤ BLANK_CYCLES < REFRESH_DIV.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, reset asynchronous and active-low.
- value  in  4*NUM_DIGITS  packed hex digits; digit 0 = value[3:0] (rightmost).
- load  in  1  capture strobe; value sampled on any clk edge with load=1.
- lz_blank_en  in  1  enables leading-zero blanking; sampled at commit.
- dp_mask  in  NUM_DIGITS  decimal-point request per digit; sampled at commit.
- digit_bin  out  4  nibble of the digit currently shown, to the decoder.
- digit_blank  out  1  1 = force all segments off (decoder output gated).
- digit_en_n  out  NUM_DIGITS  active-low digit enables; at most one bit low.
- dp_n  out  1  active-low decimal point for the current digit.
- frame_done  out  1  single-cycle pulse on each frame commit.

## Operation
- Registers: shadow (value, dp_mask, lz_blank_en), pending flag, active copy, digit index idx, slot counter cnt, state.
- load=1: shadow ← inputs, pending ← 1. Loads between commits overwrite; the last one wins.
- States: BLANK and SHOW.
  - BLANK: digit_en_n all 1, digit_blank 1, dp_n 1. Stays BLANK_CYCLES cycles, then → SHOW.
  - SHOW: digit_en_n[idx]=0, digit_bin=active nibble idx, dp_n=~dp[idx]. digit_blank=1 when idx is leading-zero blanked, otherwise 0. Stays REFRESH_DIV−BLANK_CYCLES cycles, then → BLANK with idx+1.
- Wrap: when idx=NUM_DIGITS−1 ends SHOW, idx → 0 and this is a commit.
- Commit: if pending or load is high that cycle, active ← newest data and pending ← 0. A load in the commit cycle bypasses shadow and is committed directly. frame_done=1 for that one cycle whether or not new data was committed.
- Leading-zero blanking: digit i>0 is blanked when lz_blank_en=1 and all active nibbles ≥ i are 0. Digit 0 is never blanked.
- digit_bin holds the last displayed nibble during BLANK.

## Timing
- Reset values: digit_en_n all 1, digit_bin 0, digit_blank 1, dp_n 1, frame_done 0. Internally: state BLANK, idx 0, cnt 0, shadow/active/pending 0.
- All outputs are registered and change together on the same edge. No combinational path exists from inputs to outputs.
- After rst_n rises, the first enable (digit 0) goes low on the BLANK_CYCLES-th clk edge.
- Each slot is REFRESH_DIV cycles; a frame is NUM_DIGITS*REFRESH_DIV cycles.
- Load-to-display latency: at most one frame plus BLANK_CYCLES.
- frame_done asserts on the same edge that enters BLANK for digit 0.
- rst_n falling mid-slot: all outputs go to reset values immediately. A pending load is discarded.
- NUM_DIGITS=1: every slot is a commit.

## Structure
- Shared package seg_disp_pkg: state enum (BLANK, SHOW), DIGIT_W=4 constant, and a pure function lz_mask(active, lz_en) returning a per-digit blank vector.
- Slot counter and state logic stay inline; no sub-module is required.
- The decoder is instantiated beside this block at the top level, not inside it.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset, no load → digit_en_n cycles 1110,1101,1011,0111, each low for 6 cycles after 2 all-high cycles. digit_bin=0 throughout. frame_done pulses every 32 cycles.
- load value=16'h12AF mid-frame → after the next frame_done, digit 0..3 show F, A, 2, 1. The old value persists until that commit.
- lz_blank_en=1, value=16'h0030 → digits 3 and 2 have digit_blank=1; digit 1 shows 3; digit 0 shows 0 unblanked. With value=0, only digit 0 is unblanked.
- Two loads (16'h1111, then 16'h2222) in one frame, plus a third load (16'h3333) on the commit cycle → next frame shows 3333 and pending=0.
- dp_mask=4'b0100 → dp_n=0 only during digit 2's SHOW cycles, and 1 in every BLANK.
- Assert rst_n low during digit 2 SHOW → outputs reach reset values before the next edge. After release, the scan restarts at digit 0 showing 0.
